gshare_btb_predictor: RTL and testbench
=======================================

// Module: gshare_btb_predictor
// PURPOSE
//  Parametrised gshare direction predictor with an integrated direct-mapped BTB, speculative
//  global history and mispredict recovery. Sits in IF: predicts direction and target for the
//  fetch PC in the same cycle. Trains from EX/MEM resolution one update per cycle.
//  Adds an init FSM, so the PHT can map to RAM.
// PARAMETERS
//  PC_WIDTH     32  fetch/branch PC width
//  INDEX_BITS   8   PHT index width; PHT depth = 2**INDEX_BITS 2-bit counters
//  GHR_BITS     8   global history length; legal range 1..INDEX_BITS
//  BTB_BITS     4   BTB index width; BTB depth = 2**BTB_BITS entries
//  PERF_WIDTH   32  width of the mispredict performance counter
// PORTS
//  clk            in   1           rising-edge clock
//  rst_n          in   1           asynchronous, active-low reset
//  pred_valid_i   in   1           fetch PC valid this cycle
//  pred_pc_i      in   PC_WIDTH    fetch PC
//  pred_opcode_i  in   7           opcode of fetched instruction
//  pred_ready_o   out  1           1 = init done, predictions meaningful
//  pred_taken_o   out  1           predicted taken, with valid target
//  pred_target_o  out  PC_WIDTH    predicted target, from BTB
//  pred_ghr_o     out  GHR_BITS    speculative GHR checkpoint; pipe it to EX with the branch
//  upd_valid_i    in   1           resolved control-flow instruction
//  upd_pc_i       in   PC_WIDTH    PC of resolved instruction
//  upd_ghr_i      in   GHR_BITS    checkpoint captured at predict time
//  upd_cond_i     in   1           1 = conditional branch (trains PHT)
//  upd_taken_i    in   1           actual direction
//  upd_target_i   in   PC_WIDTH    actual target
//  upd_mispred_i  in   1           direction or target was mispredicted
//  perf_mispred_o out  PERF_WIDTH  saturating count of upd_valid_i & upd_mispred_i
// BEHAVIOUR
//  Index and tag arithmetic
//  - PHT index = pc[INDEX_BITS+1:2] ^ {zero-extend ghr}.
//  - BTB index = pc[BTB_BITS+1:2]; tag = pc[PC_WIDTH-1:BTB_BITS+2].
//  FSM
//  - INIT: after reset deassert, write 2'b01 to PHT entry 0..2**INDEX_BITS-1, one per clk.
//  - RUN: entered after the last write. pred_ready_o=1 only in RUN.
//  - Reset asserted in any state returns to INIT, with the walk pointer at 0.
//  Reset values (async)
//  - spec GHR = 0; all BTB valid = 0; perf = 0.
//  - pred_ready_o = 0, pred_taken_o = 0, pred_target_o = 0, pred_ghr_o = 0.
//  Prediction (combinational, 0-cycle)
//  - BTB hit = valid & tag match.
//  - Conditional (1100011): taken = hit & counter >= 2'b10.
//  - JAL (1101111) / JALR (1100111): taken = hit.
//  - Other opcodes: taken = 0.
//  - pred_taken_o is forced to 0 when pred_valid_i=0 or in INIT.
//  - pred_target_o = BTB target on hit, else pc+4.
//  - pred_ghr_o = spec GHR before this prediction's shift.
//  Spec GHR
//  - At posedge, for a valid conditional prediction in RUN: GHR <= {GHR[GHR_BITS-2:0], pred_taken_o}.
//  - On upd_valid_i & upd_mispred_i: GHR <= upd_cond_i ? {upd_ghr_i[GHR_BITS-2:0], upd_taken_i} : upd_ghr_i.
//  - Recovery wins over a same-cycle predict shift.
//  Training (posedge, RUN only; ignored in INIT)
//  - PHT: when upd_cond_i, the counter at index(upd_pc_i, upd_ghr_i) saturates +1 if taken, -1 if not.
//    11 stays 11; 00 stays 00.
//  - BTB: on upd_taken_i, the entry is written {valid=1, tag, upd_target_i}. Not-taken never evicts.
//  Simultaneous events
//  - Predict and update to the same PHT/BTB entry in one cycle: the prediction sees the old value
//    (read-before-write).
//  - perf_mispred_o holds at all-ones.
// TESTING
//  1 Reset, release -> pred_ready_o=0 for exactly 256 clks (INIT=8), then 1; every PHT entry reads 01.
//  2 Branch pc=0x40 taken x2 with upd_target_i=0x80, mispred=1 -> next fetch of 0x40 (same GHR):
//    pred_taken_o=1, pred_target_o=0x80.
//  3 Counter at 11, four taken updates -> stays 11; then three not-taken -> 00, predict not-taken.
//  4 Spec GHR=0x5A, mispredict with upd_ghr_i=0x12, cond, taken=1 plus a same-cycle predict
//    -> pred_ghr_o=0x25 next cycle.
//  5 JAL at 0x100 cold -> not taken, target 0x104; after taken update to 0x200 -> taken, 0x200.
//  6 Assert rst_n=0 mid-INIT at step 100 -> outputs reset immediately; on release, INIT restarts at 0.

Source files
------------

// File: rtl/gshare_btb_predictor.sv
// gshare direction predictor with a direct-mapped BTB, speculative global history
// and a post-reset walk that sets every PHT counter to weakly-not-taken.
module gshare_btb_predictor #(
   parameter int PC_WIDTH   = 32,
   parameter int INDEX_BITS = 8,
   parameter int GHR_BITS   = 8,
   parameter int BTB_BITS   = 4,
   parameter int PERF_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pred_valid_i,
   input  logic [PC_WIDTH-1:0]   pred_pc_i,
   input  logic [6:0]            pred_opcode_i,
   output logic                  pred_ready_o,
   output logic                  pred_taken_o,
   output logic [PC_WIDTH-1:0]   pred_target_o,
   output logic [GHR_BITS-1:0]   pred_ghr_o,
   input  logic                  upd_valid_i,
   input  logic [PC_WIDTH-1:0]   upd_pc_i,
   input  logic [GHR_BITS-1:0]   upd_ghr_i,
   input  logic                  upd_cond_i,
   input  logic                  upd_taken_i,
   input  logic [PC_WIDTH-1:0]   upd_target_i,
   input  logic                  upd_mispred_i,
   output logic [PERF_WIDTH-1:0] perf_mispred_o
);

   localparam int PHT_DEPTH = 1 << INDEX_BITS;
   localparam int BTB_DEPTH = 1 << BTB_BITS;
   localparam int TAG_W     = PC_WIDTH - BTB_BITS - 2;

   localparam logic [6:0]            OP_BRANCH = 7'b1100011;
   localparam logic [6:0]            OP_JAL    = 7'b1101111;
   localparam logic [6:0]            OP_JALR   = 7'b1100111;
   localparam logic [INDEX_BITS-1:0] WALK_LAST = {INDEX_BITS{1'b1}};
   localparam logic [INDEX_BITS-1:0] WALK_ONE  = INDEX_BITS'(1'b1);
   localparam logic [PERF_WIDTH-1:0] PERF_MAX  = {PERF_WIDTH{1'b1}};
   localparam logic [PERF_WIDTH-1:0] PERF_ONE  = PERF_WIDTH'(1'b1);
   localparam logic [PC_WIDTH-1:0]   PC_STEP   = PC_WIDTH'(3'd4);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      if (taken) begin
         nxt = (ctr == 2'b11) ? ctr : ctr + 2'b01;
      end else begin
         nxt = (ctr == 2'b00) ? ctr : ctr - 2'b01;
      end
      return nxt;
   endfunction

   function automatic logic [INDEX_BITS-1:0] pht_index(input logic [INDEX_BITS-1:0] pc_word,
                                                       input logic [GHR_BITS-1:0]   ghr);
      return pc_word ^ INDEX_BITS'(ghr);
   endfunction

   function automatic logic [GHR_BITS-1:0] ghr_push(input logic [GHR_BITS-1:0] ghr, input logic dir);
      logic [GHR_BITS:0] ext;
      ext = {ghr, dir};
      return ext[GHR_BITS-1:0];
   endfunction

   state_t                  state_r;
   logic [INDEX_BITS-1:0]   walk_r;
   logic                    ready_r;
   logic [GHR_BITS-1:0]     ghr_r;
   logic [PERF_WIDTH-1:0]   perf_r;

   logic [1:0]              pht_r     [PHT_DEPTH];
   logic [BTB_DEPTH-1:0]    btb_valid_r;
   logic [TAG_W-1:0]        btb_tag_r [BTB_DEPTH];
   logic [PC_WIDTH-1:0]     btb_tgt_r [BTB_DEPTH];

   logic                    run_s;
   logic [INDEX_BITS-1:0]   pred_idx_s;
   logic [BTB_BITS-1:0]     pred_bidx_s;
   logic [1:0]              pred_ctr_s;
   logic                    pred_hit_s;
   logic                    pred_dir_s;
   logic                    pred_taken_s;
   logic [PC_WIDTH-1:0]     pred_target_s;
   logic                    pred_is_cond_s;
   logic [INDEX_BITS-1:0]   upd_idx_s;
   logic [BTB_BITS-1:0]     upd_bidx_s;
   logic [1:0]              upd_ctr_s;
   logic                    unused_pc_lsb_s;

   assign unused_pc_lsb_s = ^upd_pc_i[1:0];

   // Prediction lookup: PHT and BTB are read in the same cycle as the fetch
   always_comb begin
      run_s          = (state_r == ST_RUN);
      pred_idx_s     = pht_index(pred_pc_i[INDEX_BITS+1:2], ghr_r);
      pred_bidx_s    = pred_pc_i[BTB_BITS+1:2];
      pred_ctr_s     = pht_r[pred_idx_s];
      pred_hit_s     = btb_valid_r[pred_bidx_s] &&
                       (btb_tag_r[pred_bidx_s] == pred_pc_i[PC_WIDTH-1:BTB_BITS+2]);
      pred_is_cond_s = (pred_opcode_i == OP_BRANCH);
      case (pred_opcode_i)
         OP_BRANCH:        pred_dir_s = pred_hit_s && pred_ctr_s[1];
         OP_JAL, OP_JALR:  pred_dir_s = pred_hit_s;
         default:          pred_dir_s = 1'b0;
      endcase
      pred_taken_s = pred_valid_i && run_s && pred_dir_s;
      if (!run_s) begin
         pred_target_s = {PC_WIDTH{1'b0}};
      end else if (pred_hit_s) begin
         pred_target_s = btb_tgt_r[pred_bidx_s];
      end else begin
         pred_target_s = pred_pc_i + PC_STEP;
      end
   end

   // Training lookup: old counter at the resolved branch's index
   always_comb begin
      upd_idx_s  = pht_index(upd_pc_i[INDEX_BITS+1:2], upd_ghr_i);
      upd_bidx_s = upd_pc_i[BTB_BITS+1:2];
      upd_ctr_s  = pht_r[upd_idx_s];
   end

   assign pred_ready_o   = ready_r;
   assign pred_taken_o   = pred_taken_s;
   assign pred_target_o  = pred_target_s;
   assign pred_ghr_o     = ghr_r;
   assign perf_mispred_o = perf_r;

   // Init walk FSM: one PHT entry per clock, then predictions become valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_INIT;
         walk_r  <= {INDEX_BITS{1'b0}};
         ready_r <= 1'b0;
      end else begin
         case (state_r)
            ST_INIT: begin
               walk_r <= walk_r + WALK_ONE;
               if (walk_r == WALK_LAST) begin
                  state_r <= ST_RUN;
                  ready_r <= 1'b1;
               end else begin
                  state_r <= ST_INIT;
                  ready_r <= 1'b0;
               end
            end
            ST_RUN: begin
               state_r <= ST_RUN;
               ready_r <= 1'b1;
            end
            default: begin
               state_r <= ST_INIT;
               walk_r  <= {INDEX_BITS{1'b0}};
               ready_r <= 1'b0;
            end
         endcase
      end
   end

   // PHT storage: no reset so it can map onto RAM; the init walk clears it
   always_ff @(posedge clk) begin
      if (state_r == ST_INIT) begin
         pht_r[walk_r] <= 2'b01;
      end else if (upd_valid_i && upd_cond_i) begin
         pht_r[upd_idx_s] <= ctr_next(upd_ctr_s, upd_taken_i);
      end
   end

   // BTB valid bits: only taken resolutions allocate, nothing evicts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btb_valid_r <= {BTB_DEPTH{1'b0}};
      end else if (run_s && upd_valid_i && upd_taken_i) begin
         btb_valid_r[upd_bidx_s] <= 1'b1;
      end
   end

   // BTB tag and target payload
   always_ff @(posedge clk) begin
      if (run_s && upd_valid_i && upd_taken_i) begin
         btb_tag_r[upd_bidx_s] <= upd_pc_i[PC_WIDTH-1:BTB_BITS+2];
         btb_tgt_r[upd_bidx_s] <= upd_target_i;
      end
   end

   // Speculative history: recovery from a mispredict overrides the fetch shift
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ghr_r <= {GHR_BITS{1'b0}};
      end else if (upd_valid_i && upd_mispred_i) begin
         ghr_r <= upd_cond_i ? ghr_push(upd_ghr_i, upd_taken_i) : upd_ghr_i;
      end else if (pred_valid_i && run_s && pred_is_cond_s) begin
         ghr_r <= ghr_push(ghr_r, pred_taken_s);
      end
   end

   // Saturating mispredict counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_r <= {PERF_WIDTH{1'b0}};
      end else if (upd_valid_i && upd_mispred_i && (perf_r != PERF_MAX)) begin
         perf_r <= perf_r + PERF_ONE;
      end
   end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Scoreboard bench for gshare_btb_predictor: a plain-arithmetic reference model
// queues expected outputs per cycle and a negedge monitor compares them.
module tb_gshare_btb_predictor;

   localparam int PERF_MAX = 15;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_ALU  = 7'b0010011;

   typedef struct {
      logic        ready;
      logic        taken;
      logic [31:0] tgt;
      logic [7:0]  ghr;
      logic [3:0]  perf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pred_valid_i = 1'b0;
   logic [31:0] pred_pc_i = 32'd0;
   logic [6:0]  pred_opcode_i = 7'd0;
   logic        pred_ready_o;
   logic        pred_taken_o;
   logic [31:0] pred_target_o;
   logic [7:0]  pred_ghr_o;
   logic        upd_valid_i = 1'b0;
   logic [31:0] upd_pc_i = 32'd0;
   logic [7:0]  upd_ghr_i = 8'd0;
   logic        upd_cond_i = 1'b0;
   logic        upd_taken_i = 1'b0;
   logic [31:0] upd_target_i = 32'd0;
   logic        upd_mispred_i = 1'b0;
   logic [3:0]  perf_mispred_o;

   int n_checks = 0;
   int n_fail = 0;

   // reference model state
   int          m_pht[256];
   bit          m_bv[16];
   bit   [31:0] m_btag[16];
   bit   [31:0] m_btgt[16];
   int          m_ghr;
   int          m_perf;
   int          m_init_left;
   bit          m_rst;

   exp_t exp_q[$];
   exp_t mon_e;

   gshare_btb_predictor #(
      .PC_WIDTH(32), .INDEX_BITS(8), .GHR_BITS(8), .BTB_BITS(4), .PERF_WIDTH(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i), .pred_opcode_i(pred_opcode_i),
      .pred_ready_o(pred_ready_o), .pred_taken_o(pred_taken_o),
      .pred_target_o(pred_target_o), .pred_ghr_o(pred_ghr_o),
      .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_ghr_i(upd_ghr_i),
      .upd_cond_i(upd_cond_i), .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
      .upd_mispred_i(upd_mispred_i), .perf_mispred_o(perf_mispred_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("ready",  32'(pred_ready_o),   32'(mon_e.ready));
         check("taken",  32'(pred_taken_o),   32'(mon_e.taken));
         check("target", pred_target_o,       mon_e.tgt);
         check("ghr",    32'(pred_ghr_o),     32'(mon_e.ghr));
         check("perf",   32'(perf_mispred_o), 32'(mon_e.perf));
      end
   end

   task automatic model_reset();
      m_rst = 1'b1;
      m_ghr = 0;
      m_perf = 0;
      m_init_left = 256;
      for (int i = 0; i < 256; i++) m_pht[i] = 1;
      for (int i = 0; i < 16; i++) m_bv[i] = 1'b0;
   endtask

   // one clock: drive inputs, queue the expected response, advance the model
   task automatic step(input logic pv, input logic [31:0] ppc, input logic [6:0] pop,
                       input logic uv, input logic [31:0] upc, input logic [7:0] ughr,
                       input logic uc, input logic ut, input logic [31:0] utg, input logic um);
      exp_t e;
      int   pidx, bidx, uidx, ub;
      bit   run, hit, dir;
      pred_valid_i = pv; pred_pc_i = ppc; pred_opcode_i = pop;
      upd_valid_i = uv; upd_pc_i = upc; upd_ghr_i = ughr; upd_cond_i = uc;
      upd_taken_i = ut; upd_target_i = utg; upd_mispred_i = um;
      run  = !m_rst && (m_init_left == 0);
      bidx = int'((ppc >> 2) % 16);
      hit  = m_bv[bidx] && (m_btag[bidx] == (ppc >> 6));
      pidx = int'((ppc >> 2) % 256) ^ m_ghr;
      if (pop == OP_BR) dir = hit && (m_pht[pidx] >= 2);
      else if (pop == OP_JAL || pop == OP_JALR) dir = hit;
      else dir = 1'b0;
      e.ready = run;
      e.taken = pv && run && dir;
      e.tgt   = !run ? 32'd0 : (hit ? m_btgt[bidx] : ppc + 32'd4);
      e.ghr   = 8'(m_ghr);
      e.perf  = 4'(m_perf);
      exp_q.push_back(e);
      @(posedge clk);
      if (!m_rst) begin
         if (run && uv && uc) begin
            uidx = int'((upc >> 2) % 256) ^ int'(ughr);
            if (ut) m_pht[uidx] = (m_pht[uidx] == 3) ? 3 : m_pht[uidx] + 1;
            else    m_pht[uidx] = (m_pht[uidx] == 0) ? 0 : m_pht[uidx] - 1;
         end
         if (run && uv && ut) begin
            ub = int'((upc >> 2) % 16);
            m_bv[ub] = 1'b1; m_btag[ub] = upc >> 6; m_btgt[ub] = utg;
         end
         if (uv && um) m_ghr = uc ? (((int'(ughr) << 1) | int'(ut)) % 256) : int'(ughr);
         else if (run && pv && pop == OP_BR) m_ghr = ((m_ghr << 1) | int'(e.taken)) % 256;
         if (uv && um && m_perf < PERF_MAX) m_perf++;
         if (m_init_left > 0) m_init_left--;
      end
      #1;
   endtask

   function automatic logic [31:0] rnd_pc();
      return {22'd0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 2'b00};
   endfunction

   function automatic logic [6:0] rnd_op();
      logic [6:0] ops [4];
      ops[0] = OP_BR; ops[1] = OP_JAL; ops[2] = OP_JALR; ops[3] = OP_ALU;
      return ops[$urandom_range(0, 3)];
   endfunction

   task automatic idle_pred();
      step(1'($urandom_range(0, 1)), rnd_pc(), rnd_op(), 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic upd(input logic [31:0] pc, input logic [7:0] g, input logic c, input logic t,
                      input logic [31:0] tg, input logic m);
      step(1'b0, 32'd0, OP_ALU, 1'b1, pc, g, c, t, tg, m);
   endtask

   task automatic probe(input string name, input logic [31:0] pc, input logic [6:0] op,
                        input logic exp_taken, input logic [31:0] exp_tgt);
      pred_valid_i = 1'b1; pred_pc_i = pc; pred_opcode_i = op; upd_valid_i = 1'b0;
      #1;
      check({name, "_taken"}, 32'(pred_taken_o), 32'(exp_taken));
      check({name, "_target"}, pred_target_o, exp_tgt);
      step(1'b1, pc, op, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic init_and_count(input string name);
      int cnt;
      cnt = 0;
      while (!pred_ready_o && cnt < 1000) begin
         idle_pred();
         cnt++;
      end
      check(name, 32'(cnt), 32'd256);
   endtask

   initial begin
      model_reset();
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) idle_pred();
      rst_n = 1'b1; m_rst = 1'b0;
      init_and_count("init_len");

      // trained taken branch predicted with its BTB target
      upd(32'h40, 8'hFF, 1'b1, 1'b1, 32'h80, 1'b1);
      upd(32'h40, 8'hFF, 1'b1, 1'b1, 32'h80, 1'b1);
      probe("t2", 32'h40, OP_BR, 1'b1, 32'h80);

      // counter saturation at both ends
      for (int i = 0; i < 4; i++) upd(32'h40, 8'hFF, 1'b1, 1'b1, 32'h80, 1'b0);
      upd(32'h40, 8'hFF, 1'b1, 1'b0, 32'h0, 1'b0);
      probe("t3_sat_hi", 32'h40, OP_BR, 1'b1, 32'h80);
      upd(32'h40, 8'hFF, 1'b1, 1'b0, 32'h0, 1'b0);
      upd(32'h40, 8'hFF, 1'b1, 1'b0, 32'h0, 1'b0);
      probe("t3_nt", 32'h40, OP_BR, 1'b0, 32'h80);
      upd(32'h0, 8'hFF, 1'b0, 1'b0, 32'h0, 1'b1);
      upd(32'h40, 8'hFF, 1'b1, 1'b0, 32'h0, 1'b0);
      upd(32'h40, 8'hFF, 1'b1, 1'b0, 32'h0, 1'b0);
      upd(32'h40, 8'hFF, 1'b1, 1'b1, 32'h80, 1'b0);
      probe("t3_sat_lo", 32'h40, OP_BR, 1'b0, 32'h80);

      // recovery wins over a same-cycle predict shift
      upd(32'h0, 8'h5A, 1'b0, 1'b0, 32'h0, 1'b1);
      check("t4_pre_ghr", 32'(pred_ghr_o), 32'h5A);
      step(1'b1, 32'h44, OP_BR, 1'b1, 32'h300, 8'h12, 1'b1, 1'b1, 32'h380, 1'b1);
      check("t4_ghr", 32'(pred_ghr_o), 32'h25);

      // jumps: cold miss falls through, then hit after a taken update
      probe("t5_cold", 32'h100, OP_JAL, 1'b0, 32'h104);
      upd(32'h100, 8'h25, 1'b0, 1'b1, 32'h200, 1'b1);
      probe("t5_jal", 32'h100, OP_JAL, 1'b1, 32'h200);
      probe("t5_jalr", 32'h100, OP_JALR, 1'b1, 32'h200);
      probe("t5_alu", 32'h100, OP_ALU, 1'b0, 32'h200);

      for (int i = 0; i < 1500; i++) begin
         step(1'($urandom_range(0, 1)), rnd_pc(), rnd_op(),
              1'($urandom_range(0, 1)), rnd_pc(), 8'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), rnd_pc(), 1'($urandom_range(0, 3) == 0));
      end
      check("perf_sat", 32'(perf_mispred_o), 32'(PERF_MAX));

      // reset in the middle of the init walk
      model_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; m_rst = 1'b0;
      for (int i = 0; i < 100; i++) idle_pred();
      #2 rst_n = 1'b0;
      #1;
      check("t6_ready", 32'(pred_ready_o), 32'd0);
      check("t6_taken", 32'(pred_taken_o), 32'd0);
      check("t6_target", pred_target_o, 32'd0);
      check("t6_ghr", 32'(pred_ghr_o), 32'd0);
      check("t6_perf", 32'(perf_mispred_o), 32'd0);
      model_reset();
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) idle_pred();
      rst_n = 1'b1; m_rst = 1'b0;
      init_and_count("t6_init_len");
      for (int i = 0; i < 200; i++) begin
         step(1'($urandom_range(0, 1)), rnd_pc(), rnd_op(),
              1'($urandom_range(0, 1)), rnd_pc(), 8'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), rnd_pc(), 1'($urandom_range(0, 3) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
